// File: rtl/pid_axis_scheduler_if.sv
// Handshake bundle between the axis scheduler (master) and the shared PID compute unit (slave).
interface pid_axis_scheduler_if;
  logic       pid_req;
  logic [1:0] pid_axis;
  logic [7:0] pid_desired;
  logic [7:0] pid_current;
  logic       pid_ack;
  logic [7:0] pid_result;

  modport master (
    output pid_req,
    output pid_axis,
    output pid_desired,
    output pid_current,
    input  pid_ack,
    input  pid_result
  );

  modport slave (
    input  pid_req,
    input  pid_axis,
    input  pid_desired,
    input  pid_current,
    output pid_ack,
    output pid_result
  );
endinterface

// File: rtl/pid_axis_scheduler.sv
// Time-shares one PID unit across N_AXES servo axes, one pass per sample tick.
// Build macro PID_SCHED_SAFE_CENTER_EN: a timed-out axis is driven to centre instead of holding.
//
// state | meaning
// IDLE  | waiting for the sample tick
// REQ   | pid_req high for axis_q, waiting for ack or timeout
// STORE | servo_pos[axis_q] written, servo_valid pulse, advance or finish
module pid_axis_scheduler #(
  parameter int N_AXES   = 3,
  parameter int TICK_DIV = 50000,
  parameter int TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [8*N_AXES-1:0]  desired_pos,
  input  logic [8*N_AXES-1:0]  current_pos,
  pid_axis_scheduler_if.master pid,
  output logic [8*N_AXES-1:0]  servo_pos,
  output logic [N_AXES-1:0]    servo_valid,
  output logic [N_AXES-1:0]    axis_fault,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT);
  localparam logic [1:0]        AXIS_LAST = 2'(N_AXES - 1);
  localparam logic [7:0]        CENTER    = 8'd90;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    STORE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;
  logic [1:0]          axis_q, axis_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                load_req;
  logic                take_ack;
  logic                time_out;
  logic [7:0]          desired_q;
  logic [7:0]          current_q;
  logic [8*N_AXES-1:0] servo_q;
  logic [N_AXES-1:0]   axis_fault_q;
  logic                overrun_q;

  // Result is widened to 10 bits so 90 + (-128..127) cannot wrap before clamping.
  function automatic logic [7:0] sat_servo(input logic [7:0] res);
    logic signed [9:0] sum;
    sum = 10'sd90 + $signed({{2{res[7]}}, res});
    if (sum[9])
      return 8'd0;
    else if (sum > 10'sd180)
      return 8'd180;
    else
      return sum[7:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tick_cnt <= '0;
    else if (!enable)
      tick_cnt <= '0;
    else if (tick_cnt == TICK_LAST)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick = enable && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    axis_d   = axis_q;
    wait_d   = wait_q;
    load_req = 1'b0;
    take_ack = 1'b0;
    time_out = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d  = REQ;
          axis_d   = '0;
          wait_d   = '0;
          load_req = 1'b1;
        end
      end
      REQ: begin
        // An ack on the last allowed cycle wins over the timeout.
        if (pid.pid_ack) begin
          state_d  = STORE;
          take_ack = 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          state_d  = STORE;
          time_out = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      STORE: begin
        if (axis_q == AXIS_LAST) begin
          state_d = IDLE;
        end else begin
          state_d  = REQ;
          axis_d   = axis_q + 2'd1;
          wait_d   = '0;
          load_req = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axis_q       <= '0;
      wait_q       <= '0;
      desired_q    <= '0;
      current_q    <= '0;
      servo_q      <= {N_AXES{CENTER}};
      axis_fault_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      axis_q <= axis_d;
      wait_q <= wait_d;
      if (load_req) begin
        desired_q <= desired_pos[{axis_d, 3'b000} +: 8];
        current_q <= current_pos[{axis_d, 3'b000} +: 8];
      end
      // Servo is written on the edge entering STORE so it is valid with the pulse.
      if (take_ack)
        servo_q[{axis_q, 3'b000} +: 8] <= sat_servo(pid.pid_result);
      if (time_out) begin
        axis_fault_q[axis_q] <= 1'b1;
`ifdef PID_SCHED_SAFE_CENTER_EN
        servo_q[{axis_q, 3'b000} +: 8] <= CENTER;
`else
        servo_q[{axis_q, 3'b000} +: 8] <= servo_q[{axis_q, 3'b000} +: 8];
`endif
      end
      if (tick && (state_q != IDLE))
        overrun_q <= 1'b1;
    end
  end

  always_comb begin
    servo_valid = '0;
    if (state_q == STORE)
      servo_valid[axis_q] = 1'b1;
  end

  assign pid.pid_req     = (state_q == REQ);
  assign pid.pid_axis    = axis_q;
  assign pid.pid_desired = desired_q;
  assign pid.pid_current = current_q;
  assign servo_pos       = servo_q;
  assign axis_fault      = axis_fault_q;
  assign overrun         = overrun_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_pid_axis_scheduler.sv
// Bench for pid_axis_scheduler: schedule-level reference model plus a scripted PID responder.
module tb_pid_axis_scheduler;
  localparam int N        = 3;
  localparam int TICK_DIV = 12;
  localparam int TIMEOUT  = 20;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic [8*N-1:0] desired_pos = '0;
  logic [8*N-1:0] current_pos = '0;
  logic [8*N-1:0] servo_pos;
  logic [N-1:0]   servo_valid;
  logic [N-1:0]   axis_fault;
  logic           overrun;
  logic           busy;

  pid_axis_scheduler_if pid();

  pid_axis_scheduler #(.N_AXES(N), .TICK_DIV(TICK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .desired_pos(desired_pos), .current_pos(current_pos),
    .pid(pid),
    .servo_pos(servo_pos), .servo_valid(servo_valid),
    .axis_fault(axis_fault), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Responder script: ack after ack_dly[i] extra REQ cycles; > TIMEOUT means never.
  int         ack_dly [N];
  logic [7:0] res_val [N];
  bit         junk_ack = 1'b1;

  // Reference model: each accepted tick lays out the whole sequence as time windows.
  int         p;
  int         m_cnt;
  int         seq_end;
  bit         seq_on;
  int         s_start [N];
  int         s_dur   [N];
  bit         s_fault [N];
  logic [7:0] s_res   [N];
  logic [7:0] s_des   [N];
  logic [7:0] s_cur   [N];
  int         m_servo [N];
  logic [N-1:0] m_fault;
  bit         m_overrun;

  function automatic int servo_of(input logic [7:0] r);
    int v;
    v = 90 + int'($signed(r));
    if (v < 0) v = 0;
    if (v > 180) v = 180;
    return v;
  endfunction

  function automatic bit busy_at(input int q);
    return seq_on && (q >= s_start[0]) && (q <= seq_end);
  endfunction

  task automatic model_reset();
    p = 0; m_cnt = 0; seq_on = 0; seq_end = -1;
    m_fault = '0; m_overrun = 0;
    for (int i = 0; i < N; i++) begin
      m_servo[i] = 90; s_start[i] = -10; s_dur[i] = 0;
      s_des[i] = '0; s_cur[i] = '0;
    end
  endtask

  task automatic model_step();
    bit tick;
    int t;
    p++;
    tick = 0;
    if (enable) begin
      if (m_cnt == TICK_DIV - 1) begin tick = 1; m_cnt = 0; end
      else m_cnt++;
    end else m_cnt = 0;
    if (tick) begin
      if (busy_at(p - 1)) m_overrun = 1;
      else begin
        t = p;
        for (int i = 0; i < N; i++) begin
          s_start[i] = t;
          s_fault[i] = ack_dly[i] > TIMEOUT;
          s_dur[i]   = (s_fault[i] ? TIMEOUT : ack_dly[i]) + 1;
          s_res[i]   = res_val[i];
          t = t + s_dur[i] + 1;
        end
        seq_end = t - 1;
        seq_on = 1;
      end
    end
    if (seq_on) begin
      for (int i = 0; i < N; i++) begin
        if (p == s_start[i]) begin
          s_des[i] = desired_pos[8*i +: 8];
          s_cur[i] = current_pos[8*i +: 8];
        end
        if (p == s_start[i] + s_dur[i]) begin
          if (s_fault[i]) begin
            m_fault[i] = 1'b1;
`ifdef PID_SCHED_SAFE_CENTER_EN
            m_servo[i] = 90;
`endif
          end else begin
            m_servo[i] = servo_of(s_res[i]);
          end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  int busy_cnt = 0;
  int req_cnt [N];
  int age = 0;
  bit prev_req = 0;

  // Compare every cycle, gather measurements, then drive the responder for the next edge.
  initial begin
    logic         exp_req;
    int           exp_ax;
    logic [N-1:0] exp_valid;
    logic [8*N-1:0] exp_servo;
    forever begin
      @(negedge clk);
      exp_req = 0; exp_ax = 0; exp_valid = '0;
      for (int i = 0; i < N; i++) begin
        if (seq_on && p >= s_start[i] && p < s_start[i] + s_dur[i]) begin
          exp_req = 1; exp_ax = i;
        end
        if (seq_on && p == s_start[i] + s_dur[i]) exp_valid[i] = 1'b1;
        exp_servo[8*i +: 8] = 8'(m_servo[i]);
      end
      check("pid_req", 32'(pid.pid_req), 32'(exp_req));
      if (exp_req) begin
        check("pid_axis", 32'(pid.pid_axis), exp_ax);
        check("pid_desired", 32'(pid.pid_desired), 32'(s_des[exp_ax]));
        check("pid_current", 32'(pid.pid_current), 32'(s_cur[exp_ax]));
      end
      check("servo_valid", 32'(servo_valid), 32'(exp_valid));
      check("busy", 32'(busy), 32'(busy_at(p)));
      check("servo_pos", 32'(servo_pos), 32'(exp_servo));
      check("axis_fault", 32'(axis_fault), 32'(m_fault));
      check("overrun", 32'(overrun), 32'(m_overrun));

      if (busy) busy_cnt++;
      if (pid.pid_req && pid.pid_axis < 2'(N)) req_cnt[pid.pid_axis]++;

      if (pid.pid_req) begin
        age = prev_req ? age + 1 : 0;
        pid.pid_ack    = (age == ack_dly[pid.pid_axis]);
        pid.pid_result = res_val[pid.pid_axis];
      end else begin
        age = 0;
        pid.pid_ack    = junk_ack;
        pid.pid_result = 8'h81;
      end
      prev_req = pid.pid_req;
    end
  end

  task automatic set_axis(input int i, input int dly, input logic [7:0] res,
                          input logic [7:0] des, input logic [7:0] cur);
    ack_dly[i] = dly;
    res_val[i] = res;
    desired_pos[8*i +: 8] = des;
    current_pos[8*i +: 8] = cur;
  endtask

  task automatic clear_counts();
    busy_cnt = 0;
    for (int i = 0; i < N; i++) req_cnt[i] = 0;
  endtask

  // Enable until a sequence starts, drop enable mid-sequence, wait for completion.
  task automatic run_seq();
    int k;
    enable = 1'b1;
    k = 0;
    while (!busy && k < 4*TICK_DIV) begin @(negedge clk); k++; end
    check("seq_start", 32'(busy), 32'd1);
    enable = 1'b0;
    k = 0;
    while (busy && k < 300) begin @(negedge clk); k++; end
    check("seq_done", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int k;
    pid.pid_ack = 1'b0;
    pid.pid_result = '0;
    for (int i = 0; i < N; i++) begin ack_dly[i] = 0; res_val[i] = '0; req_cnt[i] = 0; end

    // Reset values and idle with enable low
    repeat (3) @(negedge clk);
    check("rst_servo_pos", 32'(servo_pos), 32'h5A5A5A);
    check("rst_pid_req", 32'(pid.pid_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    #2 rst_n = 1'b1;
    clear_counts();
    repeat (2*TICK_DIV) @(negedge clk);
    check("idle_req_count", req_cnt[0] + req_cnt[1] + req_cnt[2], 32'd0);
    check("idle_servo_pos", 32'(servo_pos), 32'h5A5A5A);

    // Nominal: desired 10, current 0, result +20, immediate ack
    for (int i = 0; i < N; i++) set_axis(i, 0, 8'd20, 8'd10, 8'd0);
    clear_counts();
    run_seq();
    check("nom_busy_cycles", busy_cnt, 32'd6);
    check("nom_req_axis1", req_cnt[1], 32'd1);
    check("nom_servo_pos", 32'(servo_pos), 32'h6E6E6E);

    // Saturation: -128 -> 0, +127 -> 180, -91 -> 0; mixed ack delays
    set_axis(0, 0, 8'h80, 8'hF0, 8'h05);
    set_axis(1, 2, 8'h7F, 8'h33, 8'h80);
    set_axis(2, 1, 8'hA5, 8'h01, 8'h7F);
    clear_counts();
    run_seq();
    check("sat_busy_cycles", busy_cnt, 32'd9);
    check("sat_servo_pos", 32'(servo_pos), 32'h00B400);

    // Axis 1 never acked; axis 2 acked exactly as the timeout expires
    set_axis(0, 0, 8'h14, 8'd5, 8'd6);
    set_axis(1, 1000, 8'h00, 8'd7, 8'd8);
    set_axis(2, TIMEOUT, 8'hEC, 8'd9, 8'd10);
    clear_counts();
    run_seq();
    check("to_req_axis1", req_cnt[1], TIMEOUT + 1);
    check("to_req_axis2", req_cnt[2], TIMEOUT + 1);
    check("to_axis_fault", 32'(axis_fault), 32'b010);
`ifdef PID_SCHED_SAFE_CENTER_EN
    check("to_servo_pos", 32'(servo_pos), 32'h465A6E);
`else
    check("to_servo_pos", 32'(servo_pos), 32'h46B46E);
`endif

    // Overrun: slow acks make the sequence longer than the tick period
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst2_axis_fault", 32'(axis_fault), 32'd0);
    for (int i = 0; i < N; i++) set_axis(i, 5, 8'(i + 1), 8'(16 + i), 8'(32 + i));
    #2 rst_n = 1'b1;
    enable = 1'b1;
    clear_counts();
    repeat (45) @(negedge clk);
    enable = 1'b0;
    k = 0;
    while (busy && k < 100) begin @(negedge clk); k++; end
    check("ovr_done", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check("ovr_overrun", 32'(overrun), 32'd1);
    check("ovr_busy_cycles", busy_cnt, 32'd42);
    check("ovr_servo_pos", 32'(servo_pos), 32'h5D5C5B);

    // Reset in the middle of the axis 2 handshake
    for (int i = 0; i < N; i++) set_axis(i, 0, 8'd10, 8'd1, 8'd2);
    ack_dly[2] = 1000;
    enable = 1'b1;
    k = 0;
    while (!(pid.pid_req && pid.pid_axis == 2'd2) && k < 60) begin @(negedge clk); k++; end
    check("mid_axis2_req", 32'(pid.pid_req && pid.pid_axis == 2'd2), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check("async_pid_req", 32'(pid.pid_req), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_servo_pos", 32'(servo_pos), 32'h5A5A5A);
    check("async_overrun", 32'(overrun), 32'd0);
    check("async_valid", 32'(servo_valid), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    ack_dly[2] = 0;
    clear_counts();
    run_seq();
    check("post_rst_busy_cycles", busy_cnt, 32'd6);
    check("post_rst_req_axis0", req_cnt[0], 32'd1);
    check("post_rst_servo_pos", 32'(servo_pos), 32'h646464);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
